mult_sat_pipe: RTL
==================

Name: mult_sat_pipe

Overview:
- Pipelined, parametrised signed fixed-point multiplier with symmetric saturation, optional round-to-nearest, overflow/underflow flags and a sticky saturation status bit.
- Uses a valid/ready handshake with full backpressure.
- Sits between the servo control-law datapath (gain × error products) and the PWM duty computation.
- Replaces the purely combinational multiplier so the product path is registered and can be stalled by downstream logic.

Parameters:
- MAGNITUD, 8, integer bits excluding sign.
- DECIMAL, 16, fractional bits.
- N (localparam), MAGNITUD+DECIMAL+1, word width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands a, b, round_en valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- a  in  N  signed Q(MAGNITUD).(DECIMAL) operand.
- b  in  N  signed Q(MAGNITUD).(DECIMAL) operand.
- round_en  in  1  1 = round half-up; 0 = truncate toward −inf. Sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  N  signed Q(MAGNITUD).(DECIMAL) product.
- ovf  out  1  positive saturation applied to current result.
- unf  out  1  negative saturation applied to current result.
- sat_sticky  out  1  set by any transferred result with ovf|unf.
- sticky_clr  in  1  clears sat_sticky.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - All stage valid bits, out_valid, result, ovf, unf and sat_sticky go to 0.
  - In-flight data is discarded.
  - in_ready is 1 in the cycle after reset deasserts.
- Pipeline: three stages.
  - S1 registers a, b, round_en.
  - S2 registers the full 2N-bit signed product P = a*b.
  - S3 registers the rounded, saturated result and flags.
  - Each stage carries a valid bit: v1, v2, v3 (v3 = out_valid).
- Advance/stall:
  - advance = ~out_valid | out_ready.
  - in_ready = advance (combinational).
  - When advance=1, all stages shift one step on the clock edge. When advance=0, all stages hold.
  - Bubbles are not collapsed.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high. Throughput: 1 result per cycle.
- Result/flags stability: result and flags must remain stable while out_valid=1 and out_ready=0.
- Arithmetic (S3):
  - If round_en=1: Pr = P + 2^(DECIMAL-1), computed at 2N+1 bits so the addition cannot wrap. Otherwise Pr = P.
  - Candidate = Pr[N-1+DECIMAL : DECIMAL].
  - Overflow exists if bits Pr[2N : N-1+DECIMAL] are not all equal.
  - If overflow and Pr is non-negative: result = MAX = 2^(N-1)-1, ovf=1.
  - If overflow and Pr is negative: result = MIN = −(2^(N-1)-1) (symmetric; encoding 1 followed by N-2 zeros and a 1), unf=1.
  - Otherwise result = candidate, ovf = unf = 0.
  - −2^(N-1) is never produced.
  - Zero operand: if a==0 or b==0 (full word), result = 0 with no flags.
- sat_sticky:
  - Set on an output transfer with ovf|unf.
  - sticky_clr has priority over a simultaneous set in the same cycle.
  - Holds otherwise.
- Reset mid-operation: overrides stall and handshake. Results accepted before reset and not yet transferred are lost.
- in_valid=1 while in_ready=0: the operands are not captured; the upstream block must hold them.

Test Plan:
- Basic product, out_ready=1: a=0x018000 (1.5), b=0x020000 (2.0), round_en=0 → result 0x030000 (3.0) exactly 3 cycles after accept, ovf=unf=0.
- Saturation: a=0x100000 (16), b=0x100000 → result 0x0FFFFFF, ovf=1, sat_sticky=1 after transfer. Then a=0x1F00000 (−16), b=0x100000 → result 0x1000001, unf=1.
- Rounding: a=0x000001, b=0x008000 (0.5):
  - round_en=0 → result 0.
  - round_en=1 → result 0x000001.
  - a=0x0FFFFFF, b=0x010000, round_en=1 → result 0x0FFFFFF, no flag.
- Backpressure: stream 6 distinct operand pairs with out_ready low for cycles 4–7 → in_ready=0 during the stall, no result lost or duplicated, outputs in order, result stable while stalled.
- Reset mid-stream: assert reset for 1 cycle with 3 products in flight and sat_sticky=1 → next cycle out_valid=0, result=0, sat_sticky=0, in_ready=1; no stale output appears afterwards.
- sticky_clr coincident with a saturating output transfer → sat_sticky=0 on the next cycle.

Source files
------------

// File: rtl/mult_sat_pipe.sv
// Three-stage signed Q(MAGNITUD).(DECIMAL) multiplier with symmetric saturation,
// optional round half-up, ovf/unf flags, sticky status and valid/ready stall.
module mult_sat_pipe #(
  parameter int MAGNITUD = 8,
  parameter int DECIMAL  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MAGNITUD+DECIMAL:0]   a,
  input  logic [MAGNITUD+DECIMAL:0]   b,
  input  logic                        round_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MAGNITUD+DECIMAL:0]   result,
  output logic                        ovf,
  output logic                        unf,
  output logic                        sat_sticky,
  input  logic                        sticky_clr
);

  localparam int N  = MAGNITUD + DECIMAL + 1;
  localparam int W2 = 2 * N;
  localparam int HI = N - 1 + DECIMAL;

  localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_V = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0] NEG_V = {1'b1, {(N-1){1'b0}}};
  localparam logic [W2:0]  HALF  =
    {{(W2+1-DECIMAL){1'b0}}, 1'b1, {(DECIMAL-1){1'b0}}};

  logic                 advance;

  logic                 v1_q, v1_d;
  logic [N-1:0]         a1_q, a1_d;
  logic [N-1:0]         b1_q, b1_d;
  logic                 r1_q, r1_d;

  logic                 v2_q, v2_d;
  logic signed [W2-1:0] p2_q, p2_d;
  logic                 r2_q, r2_d;

  logic                 v3_q, v3_d;
  logic [N-1:0]         res3_q, res3_d;
  logic                 ovf3_q, ovf3_d;
  logic                 unf3_q, unf3_d;

  logic                 sticky_q, sticky_d;

  logic [W2:0]          pr;
  logic [W2-HI:0]       upper;
  logic [N-1:0]         cand;
  logic [N-1:0]         sat_res;
  logic                 sat_ovf;
  logic                 sat_unf;

  assign advance    = ~v3_q | out_ready;
  assign in_ready   = advance;
  assign out_valid  = v3_q;
  assign result     = res3_q;
  assign ovf        = ovf3_q;
  assign unf        = unf3_q;
  assign sat_sticky = sticky_q;

  // S1: capture operands and rounding mode on an input transfer
  always_comb begin
    v1_d = v1_q;
    a1_d = a1_q;
    b1_d = b1_q;
    r1_d = r1_q;
    if (advance) begin
      v1_d = in_valid;
      if (in_valid) begin
        a1_d = a;
        b1_d = b;
        r1_d = round_en;
      end
    end
  end

  // S2: full-width signed product
  always_comb begin
    v2_d = v2_q;
    p2_d = p2_q;
    r2_d = r2_q;
    if (advance) begin
      v2_d = v1_q;
      if (v1_q) begin
        p2_d = $signed({{N{a1_q[N-1]}}, a1_q}) *
               $signed({{N{b1_q[N-1]}}, b1_q});
        r2_d = r1_q;
      end
    end
  end

  // Round at one extra bit so the half-LSB add never wraps, then saturate
  always_comb begin
    pr      = {p2_q[W2-1], p2_q} + (r2_q ? HALF : '0);
    upper   = pr[W2:HI];
    cand    = pr[HI:DECIMAL];
    sat_res = cand;
    sat_ovf = 1'b0;
    sat_unf = 1'b0;
    if (!((&upper) || !(|upper))) begin
      if (pr[W2]) begin
        sat_res = MIN_V;
        sat_unf = 1'b1;
      end else begin
        sat_res = MAX_V;
        sat_ovf = 1'b1;
      end
    end else if (cand == NEG_V) begin
      // -2^(N-1) fits the word but breaks symmetry; clamp it
      sat_res = MIN_V;
      sat_unf = 1'b1;
    end
  end

  // S3: register result and flags
  always_comb begin
    v3_d   = v3_q;
    res3_d = res3_q;
    ovf3_d = ovf3_q;
    unf3_d = unf3_q;
    if (advance) begin
      v3_d = v2_q;
      if (v2_q) begin
        res3_d = sat_res;
        ovf3_d = sat_ovf;
        unf3_d = sat_unf;
      end
    end
  end

  // Sticky saturation: clear wins over a same-cycle set
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) begin
      sticky_d = 1'b0;
    end else if (v3_q && out_ready && (ovf3_q || unf3_q)) begin
      sticky_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
      r1_q     <= 1'b0;
      v2_q     <= 1'b0;
      p2_q     <= '0;
      r2_q     <= 1'b0;
      v3_q     <= 1'b0;
      res3_q   <= '0;
      ovf3_q   <= 1'b0;
      unf3_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      r1_q     <= r1_d;
      v2_q     <= v2_d;
      p2_q     <= p2_d;
      r2_q     <= r2_d;
      v3_q     <= v3_d;
      res3_q   <= res3_d;
      ovf3_q   <= ovf3_d;
      unf3_q   <= unf3_d;
      sticky_q <= sticky_d;
    end
  end

endmodule
